vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line SHALL be configurable.
REQ-002 Parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal front porch/sync/back porch in pixels SHALL be configurable.
REQ-003 Parameter V_ACTIVE, default 480, visible lines per frame SHALL be configurable.
REQ-004 Parameters V_FP/V_SYNC/V_BP, defaults 10/2/33, vertical front porch/sync/back porch in lines SHALL be configurable.
REQ-005 Parameters HS_POL/VS_POL, default 0/0, asserted level of hsync/vsync SHALL be configurable.
REQ-006 Parameter CNT_W, default 11, width of hcount/vcount SHALL be configurable.
REQ-007 Parameter FRAME_W, default 16, width of frame_cnt SHALL be configurable.
REQ-008 clk  input  1  pixel clock; the block SHALL have one clock, and reset SHALL be asynchronous and active-low.
REQ-009 rst_n  input  1  asynchronous active-low reset.
REQ-010 en  input  1  pixel advance enable; all state SHALL hold when low.
REQ-011 hcount  output  CNT_W  current pixel column, 0..H_TOTAL-1.
REQ-012 vcount  output  CNT_W  current line, 0..V_TOTAL-1.
REQ-013 hsync/vsync  output  1 each  sync pulses at the configured polarity.
REQ-014 active  output  1  high while hcount<H_ACTIVE and vcount<V_ACTIVE.
REQ-015 line_start/frame_start  output  1 each  single-cycle strobes.
REQ-016 frame_cnt  output  FRAME_W  completed-frame count; present only with the macro in REQ-033.

Function
REQ-017 H_TOTAL SHALL equal H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default), and V_TOTAL SHALL equal V_ACTIVE+V_FP+V_SYNC+V_BP (525 by default).
REQ-018 Each clk edge with en=1 SHALL increment hcount by 1, and hcount SHALL wrap from H_TOTAL-1 to 0.
REQ-019 vcount SHALL increment only on the cycle where hcount wraps, and SHALL wrap from V_TOTAL-1 to 0 on the same edge that hcount wraps.
REQ-020 hsync SHALL be at HS_POL when H_ACTIVE+H_FP <= hcount <= H_ACTIVE+H_FP+H_SYNC-1 (656..751 by default), and at ~HS_POL otherwise.
REQ-021 vsync SHALL be at VS_POL when V_ACTIVE+V_FP <= vcount <= V_ACTIVE+V_FP+V_SYNC-1 (490..491 by default), and at ~VS_POL otherwise.
REQ-022 hsync, vsync, active, line_start and frame_start SHALL be registered and computed from next-state counts, so they are cycle-aligned with the hcount/vcount values they describe (zero relative latency).
REQ-023 line_start SHALL be high exactly while hcount==0 and en=1, and frame_start SHALL be high exactly while hcount==0, vcount==0 and en=1.
REQ-024 With en=0, counters and level outputs SHALL hold their values, and strobes SHALL be 0.
REQ-025 Arithmetic SHALL be unsigned, and instantiation SHALL fail at elaboration if H_TOTAL or V_TOTAL exceeds 2^CNT_W.
REQ-026 en toggling on any cycle, including the wrap cycle, SHALL neither skip nor duplicate a count.

Reset
REQ-027 rst_n low SHALL asynchronously force hcount=0 and vcount=0.
REQ-028 rst_n low SHALL asynchronously force hsync=~HS_POL, vsync=~VS_POL, active=1, line_start=0, frame_start=0 and frame_cnt=0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame without a frame_cnt increment.
REQ-030 After rst_n deasserts, the first enabled edge SHALL produce hcount=1.
REQ-031 Release of rst_n SHALL be synchronous to clk (synchronized upstream).

Configuration
REQ-032 Frame counting SHALL be a compile-time option.
REQ-033 With VGA_TIMING_FRAME_CNT_EN defined, port frame_cnt SHALL exist and SHALL increment by 1 when hcount and vcount both wrap, wrapping from 2^FRAME_W-1 to 0.
REQ-034 Without VGA_TIMING_FRAME_CNT_EN, port frame_cnt and its register SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-035 Reset: assert rst_n=0 mid-line at hcount=300 -> hcount=0, vcount=0, hsync=1, vsync=1, frame_cnt=0 immediately, without a clock edge.
REQ-036 Hsync: en=1, defaults -> hsync=0 exactly for hcount 656..751, active=0 from hcount 640, and line_start pulses at hcount=0.
REQ-037 Wrap: reach hcount=799 with vcount=524 -> next edge gives 0/0, frame_start=1, and frame_cnt+1 (macro on).
REQ-038 Vsync: run defaults -> vsync=0 exactly for vcount 490..491, and active=0 for vcount>=480.
REQ-039 Enable: en=0 for 5 cycles at hcount=799 -> hcount stays 799 and strobes stay 0; the first en=1 edge gives hcount=0 with vcount incremented.
REQ-040 Non-default build: H_ACTIVE=8, H_FP=H_SYNC=H_BP=2, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1, HS_POL=VS_POL=1, FRAME_W=2, macro on, 5 frames -> hsync=1 at hcount 10..11, frame_cnt sequence 1,2,3,0,1.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, sync pulses, active window and strobes.
// Define VGA_TIMING_FRAME_CNT_EN to add the completed-frame counter port frame_cnt_o.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CNT_W    = 11,
    parameter int unsigned FRAME_W  = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               en_i,
    output logic [CNT_W-1:0]   hcount_o,
    output logic [CNT_W-1:0]   vcount_o,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic               active_o,
    output logic               line_start_o,
`ifdef VGA_TIMING_FRAME_CNT_EN
    output logic               frame_start_o,
    output logic [FRAME_W-1:0] frame_cnt_o
`else
    output logic               frame_start_o
`endif
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (CNT_W < 32 && H_TOTAL > (32'd1 << CNT_W)) begin : g_h_total_chk
        $error("vga_timing_gen: H_TOTAL does not fit in CNT_W bits");
    end
    if (CNT_W < 32 && V_TOTAL > (32'd1 << CNT_W)) begin : g_v_total_chk
        $error("vga_timing_gen: V_TOTAL does not fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [CNT_W-1:0] hcount_q, hcount_d;
    logic [CNT_W-1:0] vcount_q, vcount_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             active_q, active_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;
    logic             h_wrap, v_wrap;

    assign h_wrap = (hcount_q == H_LAST);
    assign v_wrap = (vcount_q == V_LAST);

    // Decoded outputs are derived from the next counts so they line up with the counters.
    always_comb begin
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        line_start_d  = line_start_q;
        frame_start_d = frame_start_q;
        if (en_i) begin
            hcount_d = h_wrap ? '0 : hcount_q + CNT_W'(1);
            if (h_wrap) begin
                vcount_d = v_wrap ? '0 : vcount_q + CNT_W'(1);
            end
            line_start_d  = (hcount_d == '0);
            frame_start_d = (hcount_d == '0) && (vcount_d == '0);
        end
        hsync_d  = ((hcount_d >= HS_FIRST) && (hcount_d <= HS_LAST)) ? HS_POL : ~HS_POL;
        vsync_d  = ((vcount_d >= VS_FIRST) && (vcount_d <= VS_LAST)) ? VS_POL : ~VS_POL;
        active_d = (hcount_d < H_ACT) && (vcount_d < V_ACT);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            active_q      <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hcount_o      = hcount_q;
    assign vcount_o      = vcount_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign active_o      = active_q;
    // Strobe registers hold while stalled; gating with en keeps them silent during the stall.
    assign line_start_o  = line_start_q & en_i;
    assign frame_start_o = frame_start_q & en_i;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (en_i && h_wrap && v_wrap) begin
            frame_cnt_d = frame_cnt_q + FRAME_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt_o = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: three instances against a pixel-index raster model.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    int unsigned n_fail = 0;

    // Model state: number of enabled edges since reset; all instances share en and rst_n.
    longint n = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n <= 0;
        else if (en) n <= n + 1;
    end

    logic [10:0] hc_a, vc_a, hc_m, vc_m, hc_s, vc_s;
    logic hs_a, vs_a, act_a, ls_a, fs_a;
    logic hs_m, vs_m, act_m, ls_m, fs_m;
    logic hs_s, vs_s, act_s, ls_s, fs_s;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] fc_a, fc_m;
    logic [1:0]  fc_s;
`endif

    vga_timing_gen u_dflt (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .hcount_o(hc_a), .vcount_o(vc_a),
        .hsync_o(hs_a), .vsync_o(vs_a), .active_o(act_a), .line_start_o(ls_a),
`ifdef VGA_TIMING_FRAME_CNT_EN
        .frame_start_o(fs_a), .frame_cnt_o(fc_a)
`else
        .frame_start_o(fs_a)
`endif
    );

    vga_timing_gen #(.H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(4)) u_mid (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .hcount_o(hc_m), .vcount_o(vc_m),
        .hsync_o(hs_m), .vsync_o(vs_m), .active_o(act_m), .line_start_o(ls_m),
`ifdef VGA_TIMING_FRAME_CNT_EN
        .frame_start_o(fs_m), .frame_cnt_o(fc_m)
`else
        .frame_start_o(fs_m)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1),
        .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1), .FRAME_W(2)
    ) u_small (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .hcount_o(hc_s), .vcount_o(vc_s),
        .hsync_o(hs_s), .vsync_o(vs_s), .active_o(act_s), .line_start_o(ls_s),
`ifdef VGA_TIMING_FRAME_CNT_EN
        .frame_start_o(fs_s), .frame_cnt_o(fc_s)
`else
        .frame_start_o(fs_s)
`endif
    );

    task automatic finish_run();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    endtask

    task automatic check(input string tag, input longint act, input longint exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", tag, act, exp, $time);
            if (n_fail >= 200) begin
                $display("FAIL too many failures, ending run early");
                finish_run();
            end
        end
    endtask

    // Raster position follows directly from the enabled-edge count since reset.
    task automatic cmp_model(input string tag, input longint cnt,
                             input int ha, input int hfp, input int hsw, input int hbp,
                             input int va, input int vfp, input int vsw, input int vbp,
                             input bit hp, input bit vp, input bit e,
                             input longint hc, input longint vc, input bit hsy,
                             input bit vsy, input bit act, input bit ls, input bit fs);
        int ht = ha + hfp + hsw + hbp;
        int vt = va + vfp + vsw + vbp;
        int h  = int'(cnt % ht);
        int v  = int'((cnt / ht) % vt);
        bit started = (cnt > 0);
        bit exp_hs = (h >= ha + hfp && h < ha + hfp + hsw) ? hp : ~hp;
        bit exp_vs = (v >= va + vfp && v < va + vfp + vsw) ? vp : ~vp;
        check({tag, ".hcount"}, hc, h);
        check({tag, ".vcount"}, vc, v);
        check({tag, ".hsync"}, hsy, exp_hs);
        check({tag, ".vsync"}, vsy, exp_vs);
        check({tag, ".active"}, act, (h < ha && v < va) ? 1 : 0);
        check({tag, ".line_start"}, ls, (e && h == 0 && started) ? 1 : 0);
        check({tag, ".frame_start"}, fs, (e && h == 0 && v == 0 && started) ? 1 : 0);
    endtask

    bit mid_wrap_seen = 1'b0;
`ifdef VGA_TIMING_FRAME_CNT_EN
    int fs_idx = 0;
    int fseq[5] = '{1, 2, 3, 0, 1};
`endif

    always @(negedge clk) begin
        longint h_a, h_m, v_m, h_s;
        cmp_model("dflt", n, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, en,
                  hc_a, vc_a, hs_a, vs_a, act_a, ls_a, fs_a);
        cmp_model("mid", n, 40, 4, 8, 4, 480, 10, 2, 33, 1'b0, 1'b0, en,
                  hc_m, vc_m, hs_m, vs_m, act_m, ls_m, fs_m);
        cmp_model("small", n, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1, en,
                  hc_s, vc_s, hs_s, vs_s, act_s, ls_s, fs_s);
        h_a = n % 800;
        h_m = n % 56;
        v_m = (n / 56) % 525;
        h_s = n % 14;
        // Hand-derived boundary pins
        if (h_a == 656 || h_a == 751) check("pin.dflt.hsync_low", hs_a, 0);
        if (h_a == 655 || h_a == 752) check("pin.dflt.hsync_high", hs_a, 1);
        if (h_a == 640) check("pin.dflt.active_off", act_a, 0);
        if (h_a == 0 && n > 0 && en) check("pin.dflt.line_start", ls_a, 1);
        if (v_m == 490 || v_m == 491) check("pin.mid.vsync_low", vs_m, 0);
        if (v_m == 489 || v_m == 492) check("pin.mid.vsync_high", vs_m, 1);
        if (v_m == 480) check("pin.mid.active_off", act_m, 0);
        if (n == 29400 && en) begin
            check("pin.mid.wrap_h", hc_m, 0);
            check("pin.mid.wrap_v", vc_m, 0);
            check("pin.mid.frame_start", fs_m, 1);
            mid_wrap_seen = 1'b1;
        end
        if (h_s == 10 || h_s == 11) check("pin.small.hsync_on", hs_s, 1);
        if (h_s == 9 || h_s == 12) check("pin.small.hsync_off", hs_s, 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
        check("dflt.frame_cnt", fc_a, (n / 420000) % 65536);
        check("mid.frame_cnt", fc_m, (n / 29400) % 65536);
        check("small.frame_cnt", fc_s, (n / 98) % 4);
        if (n == 29400) check("pin.mid.frame_cnt", fc_m, 1);
        if (!rst_n) begin
            fs_idx = 0;
        end else if (fs_s) begin
            if (fs_idx < 5) check("pin.small.frame_seq", fc_s, fseq[fs_idx]);
            fs_idx++;
        end
`endif
    end

    initial begin
        bit hit;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        #1 en = 1'b1;
        @(negedge clk);
        check("first_edge.hcount", hc_a, 1);

        // Random stalls until column 300 on a line past the first one
        hit = 1'b0;
        for (int i = 0; i < 3000 && !hit; i++) begin
            @(negedge clk);
            if (n % 800 == 300 && n > 800) hit = 1'b1;
            else #1 en = ($urandom_range(0, 7) != 0);
        end
        check("reach_h300", hit, 1);
        check("pre_reset.hcount", hc_a, 300);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset.hcount", hc_a, 0);
        check("async_reset.vcount", vc_a, 0);
        check("async_reset.hsync", hs_a, 1);
        check("async_reset.vsync", vs_a, 1);
        check("async_reset.active", act_a, 1);
        check("async_reset.line_start", ls_a, 0);
        check("async_reset.mid_hcount", hc_m, 0);
        check("async_reset.small_hsync", hs_s, 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
        check("async_reset.frame_cnt", fc_a, 0);
`endif
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        en = 1'b1;

        // Stall at the last column of line 0
        hit = 1'b0;
        for (int i = 0; i < 1000 && !hit; i++) begin
            @(negedge clk);
            if (n % 800 == 799) hit = 1'b1;
        end
        check("reach_h799", hit, 1);
        #1 en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall.hcount", hc_a, 799);
            check("stall.line_start", ls_a, 0);
            check("stall.frame_start", fs_a, 0);
        end
        #1 en = 1'b1;
        @(negedge clk);
        check("resume.hcount", hc_a, 0);
        check("resume.vcount", vc_a, 1);
        check("resume.line_start", ls_a, 1);

        // Long random-enable run: mid instance crosses a full frame, small runs many
        for (int i = 0; i < 34000; i++) begin
            @(negedge clk);
            #1 en = ($urandom_range(0, 15) != 0);
        end
        @(negedge clk);
        check("mid.frame_wrap_reached", mid_wrap_seen, 1);
`ifdef VGA_TIMING_FRAME_CNT_EN
        check("small.frames_observed", (fs_idx >= 5) ? 1 : 0, 1);
`endif
        finish_run();
    end

endmodule
